interval_timer: RTL and testbench
=================================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CLK_DIV, 4, clk cycles per timer tick
- SHORT_TICKS, 3, ticks until short interval S expires
- LONG_TICKS, 5, ticks until long interval L expires
- DEBOUNCE, 3, consecutive stable cycles required to update C
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, single clock; all state updates on the rising edge
- R, input, 1, reset; asynchronous, active-high
- IC, input, 1, interval clear/restart from the light controller
- C_raw, input, 1, raw asynchronous car-sensor input
- S, output, 1, short interval expired
- L, output, 1, long interval expired
- C, output, 1, synchronized, debounced car-present flag
REQ-003 The parameters SHALL satisfy 1 <= SHORT_TICKS < LONG_TICKS, CLK_DIV >= 1 and DEBOUNCE >= 1; elaboration SHALL fail otherwise.

Function
REQ-004 The prescaler SHALL count 0..CLK_DIV-1 and wrap to 0, asserting an internal tick in the cycle where its value is CLK_DIV-1.
REQ-005 The tick counter SHALL increment on each tick and saturate at LONG_TICKS; it SHALL be $clog2(LONG_TICKS+1) bits wide.
REQ-006 The FSM SHALL have the states TIMING, SHORT_DONE and LONG_DONE.
- TIMING -> SHORT_DONE on the edge where the count reaches SHORT_TICKS.
- SHORT_DONE -> LONG_DONE on the edge where the count reaches LONG_TICKS.
- LONG_DONE holds until IC.
REQ-007 S SHALL be 1 in SHORT_DONE and LONG_DONE; L SHALL be 1 only in LONG_DONE; both SHALL be decoded from registered state, with no combinational path from any input.
REQ-008 IC=1 at a rising edge SHALL clear the prescaler and the count and force TIMING, so S=L=0 after that edge.
REQ-009 IC SHALL take priority over a coincident tick or state transition.
REQ-010 IC held high SHALL hold the block in its cleared condition, and timing SHALL start on the first edge where IC=0.
REQ-011 After an IC sampled at edge k, S SHALL rise after edge k+CLK_DIV*SHORT_TICKS and L SHALL rise after edge k+CLK_DIV*LONG_TICKS.
REQ-012 C_raw SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 C SHALL take the synchronized value only after that value differs from C for DEBOUNCE consecutive cycles; any return to the C value SHALL restart the stability count.
REQ-014 The debounce path SHALL be independent of IC.

Reset
REQ-015 R=1 SHALL asynchronously clear the prescaler, the count, the synchronizer flops and the debounce counter, and SHALL force state TIMING and C=0, so S=L=C=0 immediately.
REQ-016 Deasserting R SHALL begin timing on the next edge with the same behaviour as after IC.
REQ-017 Asserting R mid-interval SHALL discard all progress.

Structure
REQ-018 The shared package final_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-019 The synchronizer and debouncer SHALL be the sub-module sensor_debounce (ports clk, R, d_raw, q).
REQ-020 The prescaler, the count and the FSM SHALL reside in interval_timer.

Verification (CLK_DIV=4, SHORT_TICKS=3, LONG_TICKS=5, DEBOUNCE=3)
REQ-021 R pulse mid-count -> S=L=C=0 asynchronously, without waiting for an edge; after release, S rises 12 edges later.
REQ-022 IC pulse at edge 0 -> S=0 through edge 11 and S=1 after edge 12; L=1 after edge 20; L held indefinitely with no IC.
REQ-023 IC reasserted at edge 18, while S=1 and L=0 -> S=L=0 after edge 18; L rises after edge 38.
REQ-024 IC coincident with a tick at the SHORT_TICKS boundary -> S stays 0 and the count is 0.
REQ-025 C_raw 0->1 held -> C=1 after exactly 2 sync + 3 stable cycles; a 2-cycle C_raw glitch -> C unchanged.
REQ-026 IC held high for 10 cycles -> S=L=0 throughout; S rises 12 edges after the first edge with IC=0.

Source files
------------

// File: rtl/final_pkg.sv
// Shared types and default constants for the interval timer slice.
package final_pkg;

  typedef enum logic [1:0] {
    TIMING     = 2'd0,
    SHORT_DONE = 2'd1,
    LONG_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_SHORT_TICKS = 3;
  localparam int unsigned DEF_LONG_TICKS  = 5;
  localparam int unsigned DEF_DEBOUNCE    = 3;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for the car sensor.
module sensor_debounce
  import final_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic R,
  input  logic d_raw,
  output logic q
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] stable;

  // q follows sync2 only after DEBOUNCE consecutive disagreeing cycles
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= '0;
      q      <= 1'b0;
    end else begin
      sync1 <= d_raw;
      sync2 <= sync1;
      if (sync2 == q) begin
        stable <= '0;
      end else if (stable == DW'(DEBOUNCE - 1)) begin
        q      <= sync2;
        stable <= '0;
      end else begin
        stable <= stable + DW'(1);
      end
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Prescaled short/long interval timer with restart input and debounced car-sensor flag.
module interval_timer
  import final_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned SHORT_TICKS = DEF_SHORT_TICKS,
  parameter int unsigned LONG_TICKS  = DEF_LONG_TICKS,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic R,
  input  logic IC,
  input  logic C_raw,
  output logic S,
  output logic L,
  output logic C
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CW = $clog2(LONG_TICKS + 1);

  if (SHORT_TICKS == 0 || SHORT_TICKS >= LONG_TICKS || CLK_DIV == 0 || DEBOUNCE == 0)
  begin : g_param_check
    $error("interval_timer: illegal parameter combination");
  end

  logic [PW-1:0] presc;
  logic [CW-1:0] count;
  state_t        state;
  logic          tick;

  assign tick = (presc == PW'(CLK_DIV - 1));

  // IC outranks any coincident tick or state change
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      presc <= '0;
      count <= '0;
      state <= TIMING;
      S     <= 1'b0;
      L     <= 1'b0;
    end else if (IC) begin
      presc <= '0;
      count <= '0;
      state <= TIMING;
      S     <= 1'b0;
      L     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick && count != CW'(LONG_TICKS)) begin
        count <= count + CW'(1);
      end
      case (state)
        TIMING: begin
          if (tick && count == CW'(SHORT_TICKS - 1)) begin
            state <= SHORT_DONE;
            S     <= 1'b1;
          end
        end
        SHORT_DONE: begin
          if (tick && count == CW'(LONG_TICKS - 1)) begin
            state <= LONG_DONE;
            L     <= 1'b1;
          end
        end
        LONG_DONE: begin
          state <= LONG_DONE;
        end
        default: begin
          state <= TIMING;
          S     <= 1'b0;
          L     <= 1'b0;
        end
      endcase
    end
  end

  sensor_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk  (clk),
    .R    (R),
    .d_raw(C_raw),
    .q    (C)
  );

endmodule

// File: tb/tb_interval_timer.sv
// Directed plus randomized bench for interval_timer against an elapsed-edge reference model.
module tb_interval_timer;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned SHORT_TICKS = 3;
  localparam int unsigned LONG_TICKS  = 5;
  localparam int unsigned DEBOUNCE    = 3;
  localparam int          S_EDGES     = CLK_DIV * SHORT_TICKS;
  localparam int          L_EDGES     = CLK_DIV * LONG_TICKS;

  logic clk;
  logic R;
  logic IC;
  logic C_raw;
  logic S;
  logic L;
  logic C;

  int total = 0;
  int bad   = 0;

  // reference model: edges since last clear, raw-sample history, debounced flag
  int elapsed;
  bit hist[$];
  bit syn[$];
  bit cm;
  int since;

  interval_timer #(
    .CLK_DIV    (CLK_DIV),
    .SHORT_TICKS(SHORT_TICKS),
    .LONG_TICKS (LONG_TICKS),
    .DEBOUNCE   (DEBOUNCE)
  ) dut (
    .clk  (clk),
    .R    (R),
    .IC   (IC),
    .C_raw(C_raw),
    .S    (S),
    .L    (L),
    .C    (C)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    elapsed = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    syn.delete();
    cm    = 1'b0;
    since = 0;
  endtask

  task automatic model_edge(input logic ic, input logic raw);
    bit all_diff;
    elapsed = ic ? 0 : ((elapsed < 100000) ? elapsed + 1 : elapsed);
    syn.push_back(hist[hist.size() - 2]);
    hist.push_back(raw);
    while (hist.size() > 2) void'(hist.pop_front());
    if (since < 100000) since++;
    if (since >= DEBOUNCE) begin
      all_diff = 1'b1;
      for (int i = 0; i < DEBOUNCE; i++)
        if (syn[syn.size() - 1 - i] == cm) all_diff = 1'b0;
      if (all_diff) begin
        cm    = ~cm;
        since = 0;
      end
    end
    while (syn.size() > DEBOUNCE) void'(syn.pop_front());
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_S"}, S, elapsed >= S_EDGES);
    chk({tag, "_L"}, L, elapsed >= L_EDGES);
    chk({tag, "_C"}, C, cm);
  endtask

  task automatic step(input logic ic, input logic raw, input string tag);
    IC    = ic;
    C_raw = raw;
    @(posedge clk);
    model_edge(ic, raw);
    #1;
    check_all(tag);
  endtask

  // R raised between edges: outputs must clear before the next edge arrives
  task automatic async_reset(input string tag);
    R = 1'b1;
    #1;
    model_reset();
    chk({tag, "_async_S"}, S, 1'b0);
    chk({tag, "_async_L"}, L, 1'b0);
    chk({tag, "_async_C"}, C, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    check_all({tag, "_held"});
    R = 1'b0;
  endtask

  initial begin
    logic raw;
    int   runlen;

    R     = 1'b1;
    IC    = 1'b0;
    C_raw = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    R = 1'b0;

    // free-running after release, sensor steps 0->1 and holds
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, "release");

    // IC pulse then long hold with no IC
    step(1'b1, 1'b1, "ic0");
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, "ic_run");

    // IC reasserted at edge 18 while S=1, L=0
    step(1'b1, 1'b1, "ic_a");
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, "pre18");
    chk("pre18_S_high", S, 1'b1);
    chk("pre18_L_low", L, 1'b0);
    step(1'b1, 1'b1, "ic18");
    for (int i = 0; i < 21; i++) step(1'b0, 1'b1, "post18");

    // IC coincident with the tick that would reach SHORT_TICKS
    step(1'b1, 1'b0, "ic_b");
    for (int i = 0; i < S_EDGES - 1; i++) step(1'b0, 1'b0, "pre_tick");
    step(1'b1, 1'b0, "ic_on_tick");
    chk("ic_on_tick_count0", dut.count == '0, 1'b1);
    for (int i = 0; i < S_EDGES + 1; i++) step(1'b0, 1'b0, "after_tick");

    // IC held for 10 cycles, then timing from first low edge
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "ic_held");
    for (int i = 0; i < S_EDGES + 2; i++) step(1'b0, 1'b0, "ic_drop");

    // 2-cycle sensor glitch is rejected, 3+ cycles of stability accepted
    step(1'b0, 1'b1, "glitch");
    step(1'b0, 1'b1, "glitch");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "glitch_after");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "sensor_on");

    // async reset mid-count with C=1
    async_reset("rst_mid");
    for (int i = 0; i < S_EDGES + 4; i++) step(1'b0, 1'b0, "rst_after");

    // randomized traffic with occasional IC and reset
    raw    = 1'b0;
    runlen = 0;
    for (int i = 0; i < 800; i++) begin
      if (runlen == 0) begin
        raw    = ~raw;
        runlen = $urandom_range(1, 7);
      end
      runlen--;
      if ($urandom_range(0, 249) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step(($urandom_range(0, 34) == 0), raw, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
